i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_edge_det.sv | 36 +++
 rtl/i2s_tx.sv | 111 +++++++++++
 tb/tb_i2s_tx.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmitter: default sample width, slot counter
// sizing and the LRCLK channel encoding.
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 24;
  localparam int CNT_W        = 6;

  typedef logic [CNT_W-1:0] slot_cnt_t;

  localparam slot_cnt_t CNT_MAX = '1;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/i2s_edge_det.sv
// BCLK falling-edge detector and LRCLK slot-change detector, both evaluated
// in the clock_in domain.
module i2s_edge_det
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bclk,
  input  logic lrclk,
  output logic fall,
  output logic slot_change
);

  logic bclk_q;
  logic lr_q;
  logic first;

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_q <= 1'b0;
      lr_q   <= LEFT;
      first  <= 1'b1;
    end else begin
      bclk_q <= bclk;
      if (fall) begin
        lr_q  <= lrclk;
        first <= 1'b0;
      end
    end
  end

  // The first fall after reset only learns the LRCLK level.
  assign fall        = bclk_q & ~bclk;
  assign slot_change = fall & ~first & (lrclk != lr_q);

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-pair holding buffer, per-frame active sample registers
// and a slot bit counter that serialises MSB first with the one-BCLK delay.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                clk_3_072,
  input  logic                clk_0_0048,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                s_ready,
  output logic                sdata,
  output logic                underrun
);

  logic fall;
  logic slot_change;
  logic left_start;
  logic accept;
  logic buf_full;
  logic seen_one;
  logic armed;

  logic signed [SAMPLE_W-1:0] buf_left;
  logic signed [SAMPLE_W-1:0] buf_right;
  logic signed [SAMPLE_W-1:0] active_left;
  logic signed [SAMPLE_W-1:0] active_right;
  logic signed [SAMPLE_W-1:0] cur_sample;

  slot_cnt_t slot_cnt;
  slot_cnt_t slot_cnt_next;

  function automatic logic serial_bit(input logic signed [SAMPLE_W-1:0] smp,
                                      input slot_cnt_t n);
    logic [SAMPLE_W-1:0] shifted;
    int pos;
    pos     = int'(n);
    shifted = smp << ((pos == 0) ? 0 : pos - 1);
    serial_bit = (pos >= 1 && pos <= SAMPLE_W) ? shifted[SAMPLE_W-1] : 1'b0;
  endfunction

  i2s_edge_det u_edge_det (
    .clk         (clock_in),
    .reset       (reset),
    .bclk        (clk_3_072),
    .lrclk       (clk_0_0048),
    .fall        (fall),
    .slot_change (slot_change)
  );

  assign left_start = slot_change & (clk_0_0048 == LEFT);
  assign s_ready    = ~buf_full & ~reset;
  assign accept     = s_valid & s_ready;
  assign cur_sample = (clk_0_0048 == RIGHT) ? active_right : active_left;

  always_comb begin
    slot_cnt_next = slot_cnt;
    if (slot_change) begin
      slot_cnt_next = '0;
    end else if (fall && slot_cnt != CNT_MAX) begin
      slot_cnt_next = slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      slot_cnt     <= CNT_MAX;
      buf_full     <= 1'b0;
      active_left  <= '0;
      active_right <= '0;
      sdata        <= 1'b0;
      underrun     <= 1'b0;
      seen_one     <= 1'b0;
      armed        <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt_next;
      underrun <= left_start & ~buf_full;
      if (left_start) begin
        active_left  <= buf_full ? buf_left  : '0;
        active_right <= buf_full ? buf_right : '0;
      end
      // An accept coinciding with a left-start lands in the buffer, never in active.
      if (accept) begin
        buf_full <= 1'b1;
      end else if (left_start) begin
        buf_full <= 1'b0;
      end
      if (slot_change) begin
        seen_one <= 1'b1;
        if (seen_one) begin
          armed <= 1'b1;
        end
      end
      if (fall) begin
        sdata <= armed & serial_bit(cur_sample, slot_cnt_next);
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (accept) begin
      buf_left  <= s_left;
      buf_right <= s_right;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: BCLK = clock_in/4, LRCLK toggles on BCLK
// falls every slot_len BCLKs, expected serial frames built from sample values.
module tb_i2s_tx;

  localparam int SW = 24;

  logic          clock_in   = 1'b0;
  logic          reset      = 1'b1;
  logic          clk_3_072  = 1'b1;
  logic          clk_0_0048 = 1'b1;
  logic          s_valid    = 1'b0;
  logic [SW-1:0] s_left     = '0;
  logic [SW-1:0] s_right    = '0;
  logic          s_ready;
  logic          sdata;
  logic          underrun;

  int passed   = 0;
  int total    = 0;
  int slot_len = 32;
  int gen_k    = 31;
  int phase    = 0;
  bit fall_now = 1'b0;
  bit ls_seen  = 1'b0;

  i2s_tx #(.SAMPLE_W(SW)) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .clk_3_072  (clk_3_072),
    .clk_0_0048 (clk_0_0048),
    .s_valid    (s_valid),
    .s_left     (s_left),
    .s_right    (s_right),
    .s_ready    (s_ready),
    .sdata      (sdata),
    .underrun   (underrun)
  );

  always #5 clock_in = ~clock_in;

  // BCLK/LRCLK generator; gen_k is the BCLK index within the current slot.
  initial begin
    forever begin
      @(negedge clock_in);
      phase    = (phase + 1) % 4;
      fall_now = 1'b0;
      if (phase == 0) begin
        clk_3_072 = 1'b1;
      end else if (phase == 2) begin
        clk_3_072 = 1'b0;
        fall_now  = 1'b1;
        if (gen_k + 1 >= slot_len) begin
          gen_k      = 0;
          clk_0_0048 = ~clk_0_0048;
        end else begin
          gen_k = gen_k + 1;
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // A slot on the wire: one delay bit, the sample MSB first, then zero padding.
  function automatic logic exp_bit(input logic [SW-1:0] smp, input int k);
    logic [63:0] stream;
    stream = {1'b0, smp, 39'b0} << k;
    return stream[63];
  endfunction

  task automatic next_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock_in);
      if (fall_now) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) begin
      total++;
      $display("FAIL next_fall: no BCLK fall within 8 cycles");
    end
  endtask

  task automatic release_reset();
    bit ok;
    next_fall(ok);
    @(negedge clock_in);
    reset = 1'b0;
  endtask

  task automatic push(input string nm, input logic [SW-1:0] l, input logic [SW-1:0] r);
    @(negedge clock_in);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    #1;
    total++;
    if (s_ready !== 1'b1) $display("FAIL %s s_ready before accept got %b want 1", nm, s_ready);
    else passed++;
    @(posedge clock_in);
    #1;
    s_valid = 1'b0;
    total++;
    if (s_ready !== 1'b0) $display("FAIL %s s_ready after accept got %b want 0", nm, s_ready);
    else passed++;
  endtask

  // Checks one full frame starting at the next left-start.
  task automatic run_frame(input string nm, input logic [SW-1:0] l, input logic [SW-1:0] r,
                           input logic eu);
    bit   ok;
    bit   got;
    logic e;
    got     = 1'b0;
    ls_seen = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      next_fall(ok);
      if (!ok) break;
      if (gen_k == 0 && clk_0_0048 == 1'b0) got = 1'b1;
    end
    total++;
    if (!got) begin
      $display("FAIL %s left-start got none want one", nm);
      return;
    end
    passed++;
    ls_seen = 1'b1;
    total++;
    if (underrun !== eu) $display("FAIL %s underrun at left-start got %b want %b", nm, underrun, eu);
    else passed++;
    total++;
    if (sdata !== 1'b0) $display("FAIL %s delay bit got %b want 0", nm, sdata);
    else passed++;
    @(posedge clock_in);
    #1;
    total++;
    if (underrun !== 1'b0) $display("FAIL %s underrun next cycle got %b want 0", nm, underrun);
    else passed++;
    for (int i = 1; i < 2 * slot_len; i++) begin
      next_fall(ok);
      if (!ok) return;
      e = exp_bit(clk_0_0048 ? r : l, gen_k);
      total++;
      if (sdata !== e)
        $display("FAIL %s ch%0d bit%0d sdata got %b want %b", nm, clk_0_0048, gen_k, sdata, e);
      else passed++;
    end
  endtask

  // After reset release: silent until the second slot change, underrun at left-starts.
  task automatic post_reset_check(input string nm);
    bit   ok;
    bit   done;
    int   sc;
    logic eu;
    done = 1'b0;
    sc   = 0;
    next_fall(ok);
    total++;
    if (sdata !== 1'b0) $display("FAIL %s first fall sdata got %b want 0", nm, sdata);
    else passed++;
    for (int i = 0; i < 300 && !done; i++) begin
      next_fall(ok);
      if (!ok) break;
      total++;
      if (sdata !== 1'b0) $display("FAIL %s idle sdata got %b want 0 (k=%0d)", nm, sdata, gen_k);
      else passed++;
      if (gen_k == 0) begin
        sc++;
        eu = (clk_0_0048 == 1'b0);
        total++;
        if (underrun !== eu) $display("FAIL %s slot change underrun got %b want %b", nm, underrun, eu);
        else passed++;
      end
      if (sc >= 2 && clk_0_0048 == 1'b1 && gen_k == slot_len - 1) done = 1'b1;
    end
    total++;
    if (!done) $display("FAIL %s frame sync got none want sync", nm);
    else passed++;
  endtask

  task automatic test_reset();
    s_valid = 1'b1;
    s_left  = SW'($urandom);
    s_right = SW'($urandom);
    reset   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock_in);
      #1;
      total++;
      if (s_ready !== 1'b0) $display("FAIL reset s_ready got %b want 0", s_ready);
      else passed++;
      total++;
      if (sdata !== 1'b0) $display("FAIL reset sdata got %b want 0", sdata);
      else passed++;
      total++;
      if (underrun !== 1'b0) $display("FAIL reset underrun got %b want 0", underrun);
      else passed++;
    end
    s_valid = 1'b0;
    release_reset();
    post_reset_check("reset_release");
  endtask

  task automatic test_pattern();
    push("pattern", 24'hA50F3C, 24'h800001);
    run_frame("pattern", 24'hA50F3C, 24'h800001, 1'b0);
  endtask

  task automatic test_underrun();
    run_frame("underrun", '0, '0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] al, ar, bl, br;
    bit acc;
    al  = SW'($urandom);
    ar  = SW'($urandom);
    bl  = SW'($urandom);
    br  = SW'($urandom);
    acc = 1'b0;
    push("b2b_a", al, ar);
    fork
      run_frame("b2b_a", al, ar, 1'b0);
      begin
        s_left  = bl;
        s_right = br;
        s_valid = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b0) $display("FAIL b2b_hold s_ready got %b want 0", s_ready);
        else passed++;
        for (int i = 0; i < 400 && !acc; i++) begin
          @(negedge clock_in);
          if (s_ready) begin
            @(posedge clock_in);
            acc = 1'b1;
            total++;
            if (ls_seen !== 1'b1) $display("FAIL b2b_order accepted before left-start got %b want 1", ls_seen);
            else passed++;
            #1;
            s_valid = 1'b0;
          end
        end
        total++;
        if (!acc) $display("FAIL b2b_accept got 0 want 1");
        else passed++;
      end
    join
    run_frame("b2b_b", bl, br, 1'b0);
  endtask

  task automatic test_random();
    logic [SW-1:0] l, r;
    for (int f = 0; f < 4; f++) begin
      l = SW'($urandom);
      r = SW'($urandom);
      push("random", l, r);
      run_frame("random", l, r, 1'b0);
    end
  endtask

  task automatic test_reset_mid_slot();
    logic [SW-1:0] a, c;
    bit ok;
    bit got;
    a   = SW'($urandom) | 24'h004000;
    c   = SW'($urandom);
    got = 1'b0;
    push("midrst_a", a, SW'($urandom));
    for (int i = 0; i < 200 && !got; i++) begin
      next_fall(ok);
      if (gen_k == 0 && clk_0_0048 == 1'b0) got = 1'b1;
    end
    total++;
    if (underrun !== 1'b0) $display("FAIL midrst_a underrun got %b want 0", underrun);
    else passed++;
    push("midrst_b", SW'($urandom), SW'($urandom));
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      next_fall(ok);
      if (gen_k == 10) got = 1'b1;
    end
    total++;
    if (sdata !== exp_bit(a, 10)) $display("FAIL midrst bit10 got %b want %b", sdata, exp_bit(a, 10));
    else passed++;
    @(negedge clock_in);
    reset = 1'b1;
    @(posedge clock_in);
    #1;
    total++;
    if (sdata !== 1'b0) $display("FAIL midrst sdata after reset got %b want 0", sdata);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock_in);
      #1;
      total++;
      if (s_ready !== 1'b0) $display("FAIL midrst s_ready got %b want 0", s_ready);
      else passed++;
    end
    release_reset();
    post_reset_check("midrst_release");
    push("midrst_c", c, ~c);
    run_frame("midrst_c", c, ~c, 1'b0);
  endtask

  task automatic test_short_slot();
    logic [SW-1:0] l, r;
    for (int f = 0; f < 2; f++) begin
      l = SW'($urandom);
      r = SW'($urandom);
      push("short", l, r);
      slot_len = 20;
      run_frame("short", l, r, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_underrun();
    test_back_to_back();
    test_random();
    test_reset_mid_slot();
    test_short_slot();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
